// File: rtl/result_stream_reader_pkg.sv
// rtl/result_stream_reader_pkg.sv - shared constants and state type for the result readout path
package result_stream_reader_pkg;

  localparam int DATA_W    = 22;
  localparam int ADDR_W    = 12;
  localparam int ROW_BITS  = 10;
  localparam int COL_BITS  = ADDR_W - ROW_BITS;
  localparam int NUM_WORDS = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

endpackage

// File: rtl/result_fifo2.sv
// rtl/result_fifo2.sv - 2-entry first-word-fall-through FIFO; entry 0 is always the head
module result_fifo2 #(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] e0;
  logic [W-1:0] e1;
  logic         do_push;
  logic         do_pop;

  assign head    = e0;
  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      e0    <= '0;
      e1    <= '0;
      count <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count == 2'd0) e0 <= push_data;
          else               e1 <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          e0    <= e1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // occupancy unchanged: at one entry the new word becomes head, at two it queues behind
          if (count == 2'd1) begin
            e0 <= push_data;
          end else begin
            e0 <= e1;
            e1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/result_stream_reader.sv
// rtl/result_stream_reader.sv - reads all result SRAM words in order and streams them out with backpressure
// Optional running sum of streamed words: define RESULT_SUM_EN.
module result_stream_reader
  import result_stream_reader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [DATA_W-1:0]     sram_q,
  output logic [ROW_BITS-1:0]   sram_a,
  output logic [COL_BITS-1:0]   sram_col,
  output logic                  sram_nce,
  output logic                  sram_nwrt,
  output logic [DATA_W-1:0]     out_data,
  output logic [ADDR_W-1:0]     out_idx,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  rd_done
`ifdef RESULT_SUM_EN
  ,
  output logic [DATA_W+ADDR_W-1:0] result_sum
`endif
);

  state_t                    state;
  logic [ADDR_W:0]           addr;
  logic [ADDR_W:0]           addr_next;
  logic                      in_flight;
  logic                      issue;
  logic                      pop;
  logic                      final_hs;
  logic [2:0]                occ_next;
  logic [ADDR_W+DATA_W-1:0]  fifo_head;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [1:0]                fifo_count;
  logic                      unused_fifo_full;

  assign unused_fifo_full = fifo_full;

  assign pop      = out_valid & out_ready;
  assign final_hs = pop & out_last;
  // occupancy once this cycle's pop and any in-flight word have settled
  assign occ_next = {1'b0, fifo_count} + {2'b00, in_flight} - {2'b00, pop};
  assign issue    = (state == READ) && (occ_next <= 3'd1);
  assign addr_next = addr + {{ADDR_W{1'b0}}, 1'b1};

  assign sram_a    = addr[ADDR_W-1:COL_BITS];
  assign sram_col  = addr[COL_BITS-1:0];
  assign sram_nce  = ~issue;
  assign sram_nwrt = 1'b1;

  result_fifo2 #(
    .W(ADDR_W + DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (in_flight),
    .push_data ({addr[ADDR_W-1:0] - {{(ADDR_W-1){1'b0}}, 1'b1}, sram_q}),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid = ~fifo_empty;
  assign {out_idx, out_data} = fifo_head;
  assign out_last  = (out_idx == {ADDR_W{1'b1}});

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      addr      <= '0;
      in_flight <= 1'b0;
      busy      <= 1'b0;
      rd_done   <= 1'b0;
    end else begin
      in_flight <= issue;
      rd_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= READ;
            addr  <= '0;
            busy  <= 1'b1;
          end
        end
        READ: begin
          if (issue) begin
            addr <= addr_next;
            if (addr_next[ADDR_W]) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (final_hs) begin
            state   <= IDLE;
            busy    <= 1'b0;
            rd_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RESULT_SUM_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      result_sum <= '0;
    end else if (state == IDLE && start) begin
      result_sum <= '0;
    end else if (pop) begin
      result_sum <= result_sum + {{ADDR_W{1'b0}}, out_data};
    end
  end
`endif

endmodule

// File: tb/tb_result_stream_reader.sv
// tb/tb_result_stream_reader.sv - scoreboard bench for result_stream_reader with an SRAM model
module tb_result_stream_reader;
  import result_stream_reader_pkg::*;

  logic                  clk = 1'b0;
  logic                  rstn = 1'b0;
  logic                  start = 1'b0;
  logic                  out_ready = 1'b0;
  logic [DATA_W-1:0]     sram_q = '0;
  logic [ROW_BITS-1:0]   sram_a;
  logic [COL_BITS-1:0]   sram_col;
  logic                  sram_nce, sram_nwrt;
  logic [DATA_W-1:0]     out_data;
  logic [ADDR_W-1:0]     out_idx;
  logic                  out_valid, out_last, busy, rd_done;
`ifdef RESULT_SUM_EN
  logic [DATA_W+ADDR_W-1:0] result_sum;
`endif

  logic [DATA_W-1:0] mem [NUM_WORDS];
  longint exp_sum;
  int exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int hs_count = 0, nce_count = 0, first_hs = 0, last_hs = 0, cyc = 0;
  int ready_mode = 0;
  int mk;
  logic prev_stall = 1'b0, prev_last_hs = 1'b0;
  logic [ADDR_W+DATA_W:0] prev_word = '0;

  result_stream_reader dut (
    .clk(clk), .rstn(rstn), .start(start), .sram_q(sram_q),
    .sram_a(sram_a), .sram_col(sram_col), .sram_nce(sram_nce), .sram_nwrt(sram_nwrt),
    .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .rd_done(rd_done)
`ifdef RESULT_SUM_EN
    , .result_sum(result_sum)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) if (!sram_nce) sram_q <= mem[{sram_a, sram_col}];

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor: every handshake pops one expected index
  always @(negedge clk) begin
    if (!rstn) begin
      prev_stall   = 1'b0;
      prev_last_hs = 1'b0;
    end else begin
      if (!sram_nce) nce_count++;
      if (prev_stall) begin
        check("stall_valid_held", out_valid, 1);
        check("stall_word_held", {out_idx, out_data, out_last}, prev_word);
      end
      if (rd_done || prev_last_hs) check("rd_done_after_last", rd_done, prev_last_hs);
`ifdef RESULT_SUM_EN
      if (rd_done) check("result_sum", result_sum, exp_sum);
`endif
      prev_last_hs = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_word: got idx %0d, required no word", out_idx);
        end else begin
          mk = exp_q.pop_front();
          check("out_idx", out_idx, mk);
          check("out_data", out_data, mem[mk]);
          check("out_last", out_last, mk == NUM_WORDS - 1);
          prev_last_hs = (mk == NUM_WORDS - 1);
        end
        if (hs_count == 0) first_hs = cyc;
        last_hs = cyc;
        hs_count++;
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_idx, out_data, out_last};
    end
  end

  task automatic arm_readout();
    for (int k = 0; k < NUM_WORDS; k++) exp_q.push_back(k);
    hs_count  = 0;
    nce_count = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    arm_readout();
    @(negedge clk) start = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rd_done"}, rd_done, 0);
    check({tag, "_sram_nce"}, sram_nce, 1);
    check({tag, "_sram_nwrt"}, sram_nwrt, 1);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_idx"}, out_idx, 0);
    check({tag, "_out_last"}, out_last, 0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!rd_done && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("rd_done_seen", rd_done, 1);
    check("busy_clear_at_done", busy, 0);
    check("all_words_seen", exp_q.size(), 0);
    check("reads_issued", nce_count, NUM_WORDS);
    check("sram_nwrt_high", sram_nwrt, 1);
  endtask

  task automatic wait_hs(input int target);
    int n = 0;
    while (hs_count < target && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("reached_word", hs_count >= target, 1);
  endtask

  initial begin
    exp_sum = 0;
    for (int k = 0; k < NUM_WORDS; k++) begin
`ifdef RESULT_SUM_EN
      mem[k] = 22'h3FFFFF;
`else
      mem[k] = DATA_W'(k * 3);
`endif
      exp_sum += longint'(mem[k]);
    end

    @(negedge clk);
    check_reset_values("reset");
    @(negedge clk) rstn = 1'b1;

    // full-rate readout: latency and contiguity
    ready_mode = 0;
    @(negedge clk) start = 1'b1;
    arm_readout();
    @(negedge clk) start = 1'b0;
    check("busy_after_start", busy, 1);
    check("first_read_issued", sram_nce, 0);
    check("no_valid_edge1", out_valid, 0);
    @(negedge clk);
    check("no_valid_edge2", out_valid, 0);
    @(negedge clk);
    check("valid_after_edge3", out_valid, 1);
    check("first_idx", out_idx, 0);
    wait_done();
    check("contiguous_stream", last_hs - first_hs, NUM_WORDS - 1);
    @(negedge clk);
    check("rd_done_one_cycle", rd_done, 0);

    // random backpressure
    ready_mode = 1;
    pulse_start();
    wait_done();

    // long stall right after start
    ready_mode = 2;
    pulse_start();
    repeat (100) @(negedge clk);
    check("stall_reads_issued", nce_count, 2);
    check("stall_valid", out_valid, 1);
    check("stall_idx", out_idx, 0);
    ready_mode = 0;
    wait_done();

    // start while busy and in the final-handshake cycle is ignored; in the rd_done cycle it is taken
    pulse_start();
    wait_hs(1000);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    begin
      int n = 0;
      while (!(out_valid && out_last) && n < 20000) begin
        @(negedge clk);
        n++;
      end
    end
    start = 1'b1;
    @(negedge clk);
    check("rd_done_at_restart", rd_done, 1);
    check("first_run_complete", exp_q.size(), 0);
    arm_readout();
    @(negedge clk) start = 1'b0;
    check("busy_after_restart", busy, 1);
    wait_done();

    // asynchronous abort mid-readout, then a clean restart
    pulse_start();
    wait_hs(2000);
    #2 rstn = 1'b0;
    #1 check_reset_values("abort");
    exp_q.delete();
    @(negedge clk) rstn = 1'b1;
    pulse_start();
    wait_done();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
